seven_seg_scan_ctrl: RTL and testbench

//  Time-multiplexing scheduler for the 4-digit seven-segment display, with per-digit enable and brightness.

---
 rtl/seven_seg_scan_ctrl_if.sv | 22 ++
 rtl/seven_seg_scan_ctrl.sv | 121 ++++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/seven_seg_scan_ctrl_if.sv
// Signal bundle between the scan scheduler and its driver: tick/enable/config in, anode/slot/frame status out.
interface seven_seg_scan_ctrl_if #(
  parameter int DUTY_W = 5
);
  logic              tick;
  logic              enable;
  logic [3:0]        digit_en;
  logic [DUTY_W-1:0] duty;
  logic [3:0]        anode;
  logic [1:0]        digit_sel;
  logic              frame_done;

  modport master (
    output tick, enable, digit_en, duty,
    input  anode, digit_sel, frame_done
  );

  modport slave (
    input  tick, enable, digit_en, duty,
    output anode, digit_sel, frame_done
  );
endinterface

// File: rtl/seven_seg_scan_ctrl.sv
// Four-digit seven-segment scan scheduler: equal slots per digit, programmable lit time,
// forced dead time at the end of each slot, configuration shadowed once per frame.
module seven_seg_scan_ctrl #(
  parameter int SLOT_TICKS  = 16,
  parameter int BLANK_TICKS = 2,
  parameter int DUTY_W      = 5
) (
  input  logic                 clock,
  input  logic                 reset,
  seven_seg_scan_ctrl_if.slave bus
);

  localparam int CW = DUTY_W + 1;
  localparam logic [CW-1:0]     DUTY_MAX = CW'(SLOT_TICKS - BLANK_TICKS);
  localparam logic [DUTY_W-1:0] CNT_LAST = DUTY_W'(SLOT_TICKS - 1);

  typedef enum logic [1:0] {
    STOP = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [DUTY_W-1:0] cnt_reg, cnt_next;
  logic [1:0]        digit_sel_reg, digit_sel_next;
  logic [3:0]        en_s_reg, en_s_next;
  logic [DUTY_W-1:0] duty_s_reg, duty_s_next;
  logic [3:0]        anode_reg, anode_next;
  logic              frame_done_reg, frame_done_next;

  logic [DUTY_W-1:0] cnt_inc;
  logic [1:0]        digit_inc;

  // Widened by one bit so a duty near 2**DUTY_W-1 cannot wrap in the compare.
  function automatic logic [CW-1:0] clamp_duty(input logic [DUTY_W-1:0] d);
    logic [CW-1:0] w;
    w = {1'b0, d};
    return (w > DUTY_MAX) ? DUTY_MAX : w;
  endfunction

  function automatic logic lit(input logic [3:0]        en,
                               input logic [DUTY_W-1:0] dty,
                               input logic [1:0]        d,
                               input logic [DUTY_W-1:0] c);
    return en[d] && ({1'b0, c} < clamp_duty(dty));
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg      <= STOP;
      cnt_reg        <= '0;
      digit_sel_reg  <= '0;
      en_s_reg       <= '0;
      duty_s_reg     <= '0;
      anode_reg      <= 4'b1111;
      frame_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      digit_sel_reg  <= digit_sel_next;
      en_s_reg       <= en_s_next;
      duty_s_reg     <= duty_s_next;
      anode_reg      <= anode_next;
      frame_done_reg <= frame_done_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    digit_sel_next  = digit_sel_reg;
    en_s_next       = en_s_reg;
    duty_s_next     = duty_s_reg;
    frame_done_next = 1'b0;
    cnt_inc         = cnt_reg + 1'b1;
    digit_inc       = digit_sel_reg + 2'd1;

    case (state_reg)
      STOP: begin
        cnt_next       = '0;
        digit_sel_next = '0;
        if (bus.tick && bus.enable) begin
          en_s_next   = bus.digit_en;
          duty_s_next = bus.duty;
          state_next  = lit(bus.digit_en, bus.duty, 2'd0, '0) ? ON : OFF;
        end
      end
      default: begin
        if (bus.tick) begin
          if (cnt_reg != CNT_LAST) begin
            cnt_next   = cnt_inc;
            state_next = lit(en_s_reg, duty_s_reg, digit_sel_reg, cnt_inc) ? ON : OFF;
          end else if (digit_sel_reg != 2'd3) begin
            cnt_next       = '0;
            digit_sel_next = digit_inc;
            state_next     = lit(en_s_reg, duty_s_reg, digit_inc, '0) ? ON : OFF;
          end else begin
            // Frame wrap: the only point where enable and new configuration take effect.
            frame_done_next = 1'b1;
            cnt_next        = '0;
            digit_sel_next  = '0;
            if (bus.enable) begin
              en_s_next   = bus.digit_en;
              duty_s_next = bus.duty;
              state_next  = lit(bus.digit_en, bus.duty, 2'd0, '0) ? ON : OFF;
            end else begin
              state_next = STOP;
            end
          end
        end
      end
    endcase

    anode_next = (state_next == ON) ? ~(4'b0001 << digit_sel_next) : 4'b1111;
  end

  assign bus.anode      = anode_reg;
  assign bus.digit_sel  = digit_sel_reg;
  assign bus.frame_done = frame_done_reg;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl with SLOT_TICKS=4, BLANK_TICKS=1: per-tick anode patterns per frame.
module tb_seven_seg_scan_ctrl;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  seven_seg_scan_ctrl_if #(.DUTY_W(5)) bus_if ();

  seven_seg_scan_ctrl #(
    .SLOT_TICKS (4),
    .BLANK_TICKS(1),
    .DUTY_W     (5)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus_if)
  );

  // Anode sequence over one 16-tick frame, position 0 in the top nibble.
  localparam logic [63:0] PAT_FULL = 64'hEEEF_DDDF_BBBF_777F;
  localparam logic [63:0] PAT_0101 = 64'hEEFF_FFFF_BBFF_FFFF;
  localparam logic [63:0] PAT_DARK = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] PAT_D2   = 64'hFFFF_FFFF_BBBF_FFFF;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Runs stop_at frame positions, one tick each followed by gap-1 idle clocks.
  // At position chg_at the inputs are rewritten mid-frame.
  task automatic run_frame(input string tag, input logic [63:0] pat, input logic fd_first,
                           input int gap, input int stop_at, input int chg_at,
                           input logic chg_enable, input logic [3:0] chg_en,
                           input logic [4:0] chg_duty);
    logic [3:0] exp_an;
    for (int i = 0; i < stop_at; i++) begin
      exp_an = pat[63-4*i -: 4];
      bus_if.tick = 1'b1;
      step();
      bus_if.tick = 1'b0;
      check_eq({tag, " anode"}, 32'(bus_if.anode), 32'(exp_an));
      check_eq({tag, " digit_sel"}, 32'(bus_if.digit_sel), 32'(i / 4));
      check_eq({tag, " frame_done"}, 32'(bus_if.frame_done), 32'((i == 0) && fd_first));
      for (int g = 1; g < gap; g++) begin
        step();
        check_eq({tag, " hold anode"}, 32'(bus_if.anode), 32'(exp_an));
        check_eq({tag, " hold frame_done"}, 32'(bus_if.frame_done), 32'd0);
      end
      if (i == chg_at) begin
        bus_if.enable   = chg_enable;
        bus_if.digit_en = chg_en;
        bus_if.duty     = chg_duty;
      end
    end
    $display("frame %s: %0d positions, checks=%0d errors=%0d", tag, stop_at, checks, errors);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_if.tick     = 1'b1;
    bus_if.enable   = 1'b0;
    bus_if.digit_en = 4'b0000;
    bus_if.duty     = 5'd0;

    // Reset, then free-running tick with enable low: stays dark in STOP.
    repeat (3) step();
    check_eq("reset anode", 32'(bus_if.anode), 32'hF);
    check_eq("reset digit_sel", 32'(bus_if.digit_sel), 32'd0);
    check_eq("reset frame_done", 32'(bus_if.frame_done), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      check_eq("stop anode", 32'(bus_if.anode), 32'hF);
      check_eq("stop digit_sel", 32'(bus_if.digit_sel), 32'd0);
      check_eq("stop frame_done", 32'(bus_if.frame_done), 32'd0);
    end
    $display("stop phase: checks=%0d errors=%0d", checks, errors);

    // All digits, duty 4 clamps to 3 lit ticks per slot.
    bus_if.enable   = 1'b1;
    bus_if.digit_en = 4'b1111;
    bus_if.duty     = 5'd4;
    run_frame("full1", PAT_FULL, 1'b0, 1, 16, -1, 1'b1, 4'b1111, 5'd4);
    // Second frame repeats; config changes in digit-1 slot must not tear it.
    run_frame("full2", PAT_FULL, 1'b1, 1, 16, 5, 1'b1, 4'b0101, 5'd2);
    run_frame("en0101", PAT_0101, 1'b1, 1, 16, -1, 1'b1, 4'b0101, 5'd2);

    // duty 0: dark but constant frame rate; duty 31 clamps to 3.
    bus_if.digit_en = 4'b1111;
    bus_if.duty     = 5'd0;
    run_frame("duty0", PAT_DARK, 1'b1, 1, 16, -1, 1'b1, 4'b1111, 5'd0);
    bus_if.duty = 5'd31;
    run_frame("duty31", PAT_FULL, 1'b1, 1, 16, -1, 1'b1, 4'b1111, 5'd31);

    // Enable dropped during digit 1 with a slow tick: frame completes, then STOP.
    run_frame("slow", PAT_FULL, 1'b1, 3, 16, 5, 1'b0, 4'b1111, 5'd31);
    bus_if.tick = 1'b1;
    step();
    check_eq("wrap_stop anode", 32'(bus_if.anode), 32'hF);
    check_eq("wrap_stop digit_sel", 32'(bus_if.digit_sel), 32'd0);
    check_eq("wrap_stop frame_done", 32'(bus_if.frame_done), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("idle anode", 32'(bus_if.anode), 32'hF);
      check_eq("idle frame_done", 32'(bus_if.frame_done), 32'd0);
    end
    bus_if.enable = 1'b1;
    run_frame("restart", PAT_FULL, 1'b0, 1, 16, -1, 1'b1, 4'b1111, 5'd31);

    // Asynchronous reset while digit 2 is lit.
    bus_if.digit_en = 4'b0100;
    bus_if.duty     = 5'd3;
    run_frame("d2", PAT_D2, 1'b1, 1, 9, -1, 1'b1, 4'b0100, 5'd3);
    #2;
    reset = 1'b1;
    #1;
    check_eq("async anode", 32'(bus_if.anode), 32'hF);
    check_eq("async digit_sel", 32'(bus_if.digit_sel), 32'd0);
    check_eq("async frame_done", 32'(bus_if.frame_done), 32'd0);
    bus_if.tick = 1'b1;
    step();
    check_eq("in_reset anode", 32'(bus_if.anode), 32'hF);
    reset = 1'b0;
    bus_if.digit_en = 4'b1111;
    bus_if.duty     = 5'd4;
    run_frame("post_reset", PAT_FULL, 1'b0, 1, 16, -1, 1'b1, 4'b1111, 5'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
